// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 pipeline constants
// Purpose: datapath width defaults, ALU operation codes and forwarding
// select codes shared by the EX stage and its ALU.
// Ports: none (package).
package legv8_pkg;

  localparam int LEGV8_DW = 64;
  localparam int LEGV8_RW = 5;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - combinational LEGv8 ALU
// Purpose: computes a (ctl) b truncated to DW bits and the zero flag.
// Ports:
//   a, b   in  DW  operands
//   ctl    in  4   operation code (ALU_* in legv8_pkg)
//   result out DW  operation result, 0 for unknown codes
//   zero   out 1   result == 0
module alu64
  import legv8_pkg::*;
#(
  parameter int DW = LEGV8_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    ctl,
  output logic [DW-1:0] result,
  output logic          zero
);

  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_PASSB: result = b;
      ALU_NOR:   result = ~(a | b);
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - LEGv8 EX stage with EX/MEM pipeline register
// Purpose: operand forwarding, ALU operand select, ALU, branch target adder
// and the EX/MEM register feeding the Memory stage.
// Ports:
//   clk, resetl                 clock / async active-low reset
//   stall, flush                hold / bubble the EX/MEM register
//   *_EX control bits, ALUSrc_EX, ALUCtl_EX, RD_EX, PC_EX,
//   RegOutA_EX, RegOutB_EX, SignExtImm_EX   ID/EX inputs
//   ForwardA, ForwardB, ALUout_fwd, WBdata_fwd  forwarding controls/sources
//   *_MEM                       registered outputs to the Memory stage
module execute_stage
  import legv8_pkg::*;
#(
  parameter int DW = LEGV8_DW,
  parameter int RW = LEGV8_RW
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          stall,
  input  logic          flush,
  input  logic          RegWrite_EX,
  input  logic          Branch_EX,
  input  logic          Uncondbranch_EX,
  input  logic          MemRead_EX,
  input  logic          MemWrite_EX,
  input  logic          Mem2Reg_EX,
  input  logic          ALUSrc_EX,
  input  logic [3:0]    ALUCtl_EX,
  input  logic [RW-1:0] RD_EX,
  input  logic [DW-1:0] PC_EX,
  input  logic [DW-1:0] RegOutA_EX,
  input  logic [DW-1:0] RegOutB_EX,
  input  logic [DW-1:0] SignExtImm_EX,
  input  logic [1:0]    ForwardA,
  input  logic [1:0]    ForwardB,
  input  logic [DW-1:0] ALUout_fwd,
  input  logic [DW-1:0] WBdata_fwd,
  output logic          RegWrite_MEM,
  output logic          Branch_MEM,
  output logic          Uncondbranch_MEM,
  output logic          MemRead_MEM,
  output logic          MemWrite_MEM,
  output logic          Mem2Reg_MEM,
  output logic          ALUzero_MEM,
  output logic [RW-1:0] RD_MEM,
  output logic [DW-1:0] ALUout_MEM,
  output logic [DW-1:0] RegOutB_MEM,
  output logic [DW-1:0] PCtarget_MEM
);

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic [DW-1:0] pc_target;

  // Select 11 is unused by the hazard unit and falls back to the register value.
  always_comb begin
    fwd_a = RegOutA_EX;
    case (ForwardA)
      FWD_MEM: fwd_a = ALUout_fwd;
      FWD_WB:  fwd_a = WBdata_fwd;
      default: fwd_a = RegOutA_EX;
    endcase
  end

  always_comb begin
    fwd_b = RegOutB_EX;
    case (ForwardB)
      FWD_MEM: fwd_b = ALUout_fwd;
      FWD_WB:  fwd_b = WBdata_fwd;
      default: fwd_b = RegOutB_EX;
    endcase
  end

  // Store data is the forwarded B, taken before the immediate mux.
  assign op_b      = ALUSrc_EX ? SignExtImm_EX : fwd_b;
  assign pc_target = PC_EX + (SignExtImm_EX << 2);

  alu64 #(.DW(DW)) u_alu (
    .a      (fwd_a),
    .b      (op_b),
    .ctl    (ALUCtl_EX),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      RegWrite_MEM     <= 1'b0;
      Branch_MEM       <= 1'b0;
      Uncondbranch_MEM <= 1'b0;
      MemRead_MEM      <= 1'b0;
      MemWrite_MEM     <= 1'b0;
      Mem2Reg_MEM      <= 1'b0;
      ALUzero_MEM      <= 1'b0;
      RD_MEM           <= '0;
      ALUout_MEM       <= '0;
      RegOutB_MEM      <= '0;
      PCtarget_MEM     <= '0;
    end else if (flush || !stall) begin
      // A bubble clears every control bit and RD so nothing downstream
      // writes memory or the register file; data fields load regardless.
      RegWrite_MEM     <= flush ? 1'b0 : RegWrite_EX;
      Branch_MEM       <= flush ? 1'b0 : Branch_EX;
      Uncondbranch_MEM <= flush ? 1'b0 : Uncondbranch_EX;
      MemRead_MEM      <= flush ? 1'b0 : MemRead_EX;
      MemWrite_MEM     <= flush ? 1'b0 : MemWrite_EX;
      Mem2Reg_MEM      <= flush ? 1'b0 : Mem2Reg_EX;
      RD_MEM           <= flush ? '0 : RD_EX;
      ALUzero_MEM      <= alu_zero;
      ALUout_MEM       <= alu_result;
      RegOutB_MEM      <= fwd_b;
      PCtarget_MEM     <= pc_target;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

  logic        clk;
  logic        resetl;
  logic        stall, flush;
  logic        RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX, Mem2Reg_EX;
  logic        ALUSrc_EX;
  logic [3:0]  ALUCtl_EX;
  logic [4:0]  RD_EX;
  logic [63:0] PC_EX, RegOutA_EX, RegOutB_EX, SignExtImm_EX;
  logic [1:0]  ForwardA, ForwardB;
  logic [63:0] ALUout_fwd, WBdata_fwd;
  logic        RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM;
  logic        ALUzero_MEM;
  logic [4:0]  RD_MEM;
  logic [63:0] ALUout_MEM, RegOutB_MEM, PCtarget_MEM;

  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clk(clk), .resetl(resetl), .stall(stall), .flush(flush),
    .RegWrite_EX(RegWrite_EX), .Branch_EX(Branch_EX), .Uncondbranch_EX(Uncondbranch_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Mem2Reg_EX(Mem2Reg_EX),
    .ALUSrc_EX(ALUSrc_EX), .ALUCtl_EX(ALUCtl_EX), .RD_EX(RD_EX), .PC_EX(PC_EX),
    .RegOutA_EX(RegOutA_EX), .RegOutB_EX(RegOutB_EX), .SignExtImm_EX(SignExtImm_EX),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .ALUout_fwd(ALUout_fwd), .WBdata_fwd(WBdata_fwd),
    .RegWrite_MEM(RegWrite_MEM), .Branch_MEM(Branch_MEM), .Uncondbranch_MEM(Uncondbranch_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Mem2Reg_MEM(Mem2Reg_MEM),
    .ALUzero_MEM(ALUzero_MEM), .RD_MEM(RD_MEM), .ALUout_MEM(ALUout_MEM),
    .RegOutB_MEM(RegOutB_MEM), .PCtarget_MEM(PCtarget_MEM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural reference ----------------
  typedef struct packed {
    logic [5:0]  ctl;   // {RegWrite, Branch, Uncondbranch, MemRead, MemWrite, Mem2Reg}
    logic        zero;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] stb;
    logic [63:0] tgt;
    logic        dc;    // data fields hold bubble garbage
  } exp_t;

  exp_t exp_s;

  function automatic logic [63:0] pick(input logic [1:0] sel, input logic [63:0] r,
                                       input logic [63:0] m, input logic [63:0] w);
    if (sel == 2'b10) return m;
    if (sel == 2'b01) return w;
    return r;
  endfunction

  function automatic logic [63:0] alu_ref(input logic [3:0] c, input logic [63:0] a,
                                          input logic [63:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or negedge resetl) begin
    logic [63:0] fa, fb, r;
    if (!resetl) begin
      exp_s = '0;
    end else if (flush || !stall) begin
      fa = pick(ForwardA, RegOutA_EX, ALUout_fwd, WBdata_fwd);
      fb = pick(ForwardB, RegOutB_EX, ALUout_fwd, WBdata_fwd);
      r  = alu_ref(ALUCtl_EX, fa, ALUSrc_EX ? SignExtImm_EX : fb);
      exp_s.alu  = r;
      exp_s.zero = (r == 64'd0);
      exp_s.stb  = fb;
      exp_s.tgt  = PC_EX + SignExtImm_EX * 64'd4;
      if (flush) begin
        exp_s.ctl = 6'd0;
        exp_s.rd  = 5'd0;
        exp_s.dc  = 1'b1;
      end else begin
        exp_s.ctl = {RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX, Mem2Reg_EX};
        exp_s.rd  = RD_EX;
        exp_s.dc  = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Cycle compare: outputs are sampled on the falling edge.
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_ctl", {RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM},
          {58'd0, exp_s.ctl});
      chk("cmp_rd", {59'd0, RD_MEM}, {59'd0, exp_s.rd});
      if (!exp_s.dc) begin
        chk("cmp_alu",  ALUout_MEM,   exp_s.alu);
        chk("cmp_zero", {63'd0, ALUzero_MEM}, {63'd0, exp_s.zero});
        chk("cmp_stb",  RegOutB_MEM,  exp_s.stb);
        chk("cmp_tgt",  PCtarget_MEM, exp_s.tgt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    stall = 0; flush = 0;
    RegWrite_EX = 0; Branch_EX = 0; Uncondbranch_EX = 0;
    MemRead_EX = 0; MemWrite_EX = 0; Mem2Reg_EX = 0;
    ALUSrc_EX = 0; ALUCtl_EX = 4'b0010; RD_EX = 0; PC_EX = 0;
    RegOutA_EX = 0; RegOutB_EX = 0; SignExtImm_EX = 0;
    ForwardA = 0; ForwardB = 0; ALUout_fwd = 0; WBdata_fwd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 3))
      0:       return 64'($urandom_range(0, 15));
      1:       return {$urandom, $urandom};
      2:       return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      default: return 64'($urandom);
    endcase
  endfunction

  task automatic randomize_inputs();
    logic [3:0] codes [7];
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0110;
    codes[4] = 4'b0111; codes[5] = 4'b1100; codes[6] = 4'($urandom);
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 6) == 0);
    {RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX, Mem2Reg_EX} = 6'($urandom);
    ALUSrc_EX = 1'($urandom);
    ALUCtl_EX = codes[$urandom_range(0, 6)];
    RD_EX = 5'($urandom);
    PC_EX = rnd64();
    RegOutA_EX = rnd64();
    RegOutB_EX = ($urandom_range(0, 5) == 0) ? RegOutA_EX : rnd64();
    SignExtImm_EX = rnd64();
    ForwardA = 2'($urandom);
    ForwardB = 2'($urandom);
    ALUout_fwd = rnd64();
    WBdata_fwd = rnd64();
  endtask

  initial begin
    idle();
    resetl = 1'b0;
    #1;
    chk("reset_alu", ALUout_MEM, 64'd0);
    chk("reset_ctl", {RegWrite_MEM, MemWrite_MEM, MemRead_MEM, Branch_MEM, Uncondbranch_MEM, Mem2Reg_MEM, ALUzero_MEM}, 64'd0);
    chk("reset_rd", {59'd0, RD_MEM}, 64'd0);
    #13;
    resetl = 1'b1;
    cmp_en = 1'b1;

    // ADD, no forwarding
    RegOutA_EX = 5; RegOutB_EX = 7; ALUCtl_EX = 4'b0010;
    tick();
    chk("add_alu", ALUout_MEM, 64'd12);
    chk("add_zero", {63'd0, ALUzero_MEM}, 64'd0);
    chk("add_stb", RegOutB_MEM, 64'd7);

    // SUB to zero with branch target
    idle();
    RegOutA_EX = 64'h20; RegOutB_EX = 64'h20; ALUCtl_EX = 4'b0110;
    Branch_EX = 1; PC_EX = 64'h100; SignExtImm_EX = 4;
    tick();
    chk("sub_zero", {63'd0, ALUzero_MEM}, 64'd1);
    chk("sub_branch", {63'd0, Branch_MEM}, 64'd1);
    chk("sub_target", PCtarget_MEM, 64'h110);

    // Forwarding from both sources
    idle();
    RegOutA_EX = 1; ALUout_fwd = 9; ForwardA = 2'b10;
    RegOutB_EX = 3; WBdata_fwd = 4; ForwardB = 2'b01;
    ALUSrc_EX = 1; SignExtImm_EX = 8; ALUCtl_EX = 4'b0010;
    tick();
    chk("fwd_alu", ALUout_MEM, 64'd17);
    chk("fwd_stb", RegOutB_MEM, 64'd4);
    ForwardA = 2'b11;
    tick();
    chk("fwd11_alu", ALUout_MEM, 64'd9);

    // Stall holds a normal entry
    idle();
    RegWrite_EX = 1; RD_EX = 7; RegOutA_EX = 5; RegOutB_EX = 7;
    tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      RegOutA_EX = 64'(100 + i); RegWrite_EX = 0; RD_EX = 5'(20 + i);
      tick();
      chk("stall_alu", ALUout_MEM, 64'd12);
      chk("stall_rw", {63'd0, RegWrite_MEM}, 64'd1);
      chk("stall_rd", {59'd0, RD_MEM}, 64'd7);
    end

    // Flush beats stall, then the bubble is held
    idle();
    stall = 1; flush = 1; MemWrite_EX = 1; RegWrite_EX = 1; RD_EX = 3;
    RegOutA_EX = 10; RegOutB_EX = 6;
    tick();
    chk("flush_mw", {63'd0, MemWrite_MEM}, 64'd0);
    chk("flush_rw", {63'd0, RegWrite_MEM}, 64'd0);
    chk("flush_rd", {59'd0, RD_MEM}, 64'd0);
    flush = 0;
    for (int i = 0; i < 2; i++) begin
      MemRead_EX = 1; Mem2Reg_EX = 1; RD_EX = 5'(11 + i);
      tick();
      chk("bubble_hold_ctl", {RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM}, 64'd0);
      chk("bubble_hold_rd", {59'd0, RD_MEM}, 64'd0);
    end

    // Asynchronous reset in the middle of a cycle
    idle();
    RegWrite_EX = 1; RD_EX = 9; RegOutA_EX = 5; RegOutB_EX = 7; PC_EX = 64'h40; SignExtImm_EX = 1;
    tick();
    chk("pre_reset_alu", ALUout_MEM, 64'd12);
    #1 resetl = 1'b0;
    #1;
    chk("async_alu", ALUout_MEM, 64'd0);
    chk("async_stb", RegOutB_MEM, 64'd0);
    chk("async_tgt", PCtarget_MEM, 64'd0);
    chk("async_ctl_rd", {RegWrite_MEM, RD_MEM}, 64'd0);
    #1 resetl = 1'b1;
    RegOutA_EX = 2; RegOutB_EX = 3; RD_EX = 4;
    tick();
    chk("post_reset_alu", ALUout_MEM, 64'd5);
    chk("post_reset_rd", {59'd0, RD_MEM}, 64'd4);

    // Wrap, NOR, undefined code
    idle();
    RegOutA_EX = 64'hFFFF_FFFF_FFFF_FFFF; RegOutB_EX = 1;
    tick();
    chk("wrap_alu", ALUout_MEM, 64'd0);
    chk("wrap_zero", {63'd0, ALUzero_MEM}, 64'd1);
    RegOutA_EX = 0; RegOutB_EX = 0; ALUCtl_EX = 4'b1100;
    tick();
    chk("nor_alu", ALUout_MEM, 64'hFFFF_FFFF_FFFF_FFFF);
    RegOutA_EX = 5; RegOutB_EX = 7; ALUCtl_EX = 4'b1111;
    tick();
    chk("undef_alu", ALUout_MEM, 64'd0);
    chk("undef_zero", {63'd0, ALUzero_MEM}, 64'd1);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      tick();
      if ($urandom_range(0, 149) == 0) begin
        #1 resetl = 1'b0;
        #1;
        chk("rand_async_alu", ALUout_MEM, 64'd0);
        chk("rand_async_ctl", {RegWrite_MEM, MemWrite_MEM, RD_MEM}, 64'd0);
        #1 resetl = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage 64-bit LEGv8 pipeline. Sits directly upstream of the Memory stage.
- Resolves operand forwarding, selects the ALU second operand, computes the ALU result, zero flag and branch target.
- Captures the result plus MEM/WB control bits in the EX/MEM pipeline register that drives the Memory stage inputs.
- Supports stall (hold) and flush (bubble) from hazard/branch logic.

Parameters:
- DW, 64, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock, all state on rising edge
- resetl  in  1  reset, asynchronous, active-low
- stall  in  1  hold EX/MEM register contents
- flush  in  1  replace next EX/MEM entry with bubble (driven by Memory-stage PCSrc)
- RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX, Mem2Reg_EX  in  1 each  control bits from ID/EX
- ALUSrc_EX  in  1  0 = forwarded B, 1 = SignExtImm_EX
- ALUCtl_EX  in  4  ALU operation code
- RD_EX  in  RW  destination register
- PC_EX  in  DW  instruction PC
- RegOutA_EX, RegOutB_EX  in  DW  register-file read data
- SignExtImm_EX  in  DW  sign-extended immediate
- ForwardA, ForwardB  in  2  forwarding selects
- ALUout_fwd  in  DW  EX/MEM ALU result (forward source)
- WBdata_fwd  in  DW  writeback result (forward source)
- RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM  out  1 each  registered control
- ALUzero_MEM  out  1  registered zero flag
- RD_MEM  out  RW  registered destination
- ALUout_MEM, RegOutB_MEM, PCtarget_MEM  out  DW  registered ALU result, store data, branch target

Behaviour:
- Forwarding mux, applied separately to A and B:
  - 00: register value
  - 10: ALUout_fwd
  - 01: WBdata_fwd
  - 11: register value
- opB = ALUSrc_EX ? SignExtImm_EX : fwdB. Store data = fwdB, always taken before the ALUSrc mux.
- ALUCtl (fwdA op opB), result truncated to DW bits, carries and overflow discarded:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 pass opB
  - 1100 NOR
  - any other code: result 0
- zero = (result == 0).
- PCtarget = PC_EX + (SignExtImm_EX << 2), modulo 2^DW.
- Latency: 1 cycle. Inputs sampled at edge N appear on *_MEM outputs after edge N.
- EX/MEM register update priority, per rising edge:
  1. resetl low (asynchronous, immediate): every output 0, including all control bits, RD_MEM, ALUzero_MEM and the data buses.
  2. flush = 1: bubble. All six control bits = 0 and RD_MEM = 0. Data fields load normally (don't-care). Flush wins over a simultaneous stall.
  3. stall = 1: all fields hold their previous values.
  4. Otherwise: all fields load the new values.
- Reset mid-operation: the in-flight EX/MEM entry is discarded. The first post-reset edge with no stall or flush loads normally.
- A bubble must never cause a memory write or a register write downstream.
- Combinational paths: none from inputs to outputs; every output is a flop.

Decomposition:
- Shared package `legv8_pkg`:
  - ALUCtl localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR
  - forward-select localparams: FWD_REG, FWD_MEM, FWD_WB
  - DW and RW defaults
- One sub-module `alu64`: combinational; inputs a, b, ctl; outputs result, zero.
- Forward muxes, target adder and EX/MEM register stay in execute_stage.

Test Plan:
- ADD, no forwarding: A=5, B=7, ALUCtl=0010, ALUSrc=0 → next edge ALUout_MEM=12, ALUzero_MEM=0, RegOutB_MEM=7.
- SUB zero plus branch target: A=B=0x20, ALUCtl=0110, Branch_EX=1, PC=0x100, Imm=4 → ALUzero_MEM=1, Branch_MEM=1, PCtarget_MEM=0x110.
- Forwarding, both sources in one test:
  - A=1, ALUout_fwd=9, ForwardA=10, B=3, WBdata_fwd=4, ForwardB=01, ALUSrc=1, Imm=8, ADD → ALUout_MEM=17, RegOutB_MEM=4.
  - ForwardA=11 → ALUout_MEM uses A=1.
- Flush versus stall: MemWrite_EX=1, RegWrite_EX=1, RD=3, stall=1 and flush=1 → all control bits 0, RD_MEM=0. Then stall=1 alone for 2 cycles with changing inputs → outputs unchanged.
- Async reset: drop resetl mid-cycle while outputs are nonzero → all outputs 0 before the next clk edge. Release resetl, then the first edge loads the current inputs.
- Wrap and NOR:
  - A=0xFFFF_FFFF_FFFF_FFFF, B=1, ADD → ALUout_MEM=0, ALUzero_MEM=1.
  - NOR with A=0, B=0 → result all-ones.
  - ALUCtl=1111 → result 0.
